// File: rtl/sig_pkg.sv
// Shared types and constants for the signal router: FSM states, display codes
// and the idle "HELLO" message builder.
package sig_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUTE,
      ST_BANNER,
      ST_LIVE
   } state_e;

   localparam int unsigned   MAX_DIGITS  = 16;
   localparam int unsigned   MSG_W       = MAX_DIGITS * 4;
   localparam logic [3:0]    DIG_BLANK   = 4'hD;
   localparam logic [19:0]   HELLO_CODES = {4'h6, 4'hE, 4'h7, 4'h7, 4'h0};

   // "HELLO" in the top five digits, blanks below; n_dig must be 5..MAX_DIGITS
   function automatic logic [MSG_W-1:0] idle_msg(input int unsigned n_dig);
      logic [MSG_W-1:0] msg;
      logic [3:0]       nib;
      msg = '0;
      for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
         nib = '0;
         if (i < n_dig - 5) begin
            nib = DIG_BLANK;
         end else if (i < n_dig) begin
            nib = 4'(HELLO_CODES >> (4 * (i - (n_dig - 5))));
         end
         msg = msg | (MSG_W'(nib) << (4 * i));
      end
      return msg;
   endfunction

endpackage

// File: rtl/sel_sync.sv
// Two-flop synchroniser for the raw select switches; codes above N_SRC are
// clamped to the idle code on the second stage.
module sel_sync #(
   parameter int unsigned N_SRC = 3,
   parameter int unsigned SEL_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [SEL_W-1:0] sel_raw,
   output logic [SEL_W-1:0] sel_s
);

   logic [SEL_W-1:0] meta_q;
   logic [SEL_W-1:0] sync_q;
   logic [SEL_W-1:0] sync_d;

   always_comb begin
      sync_d = meta_q;
      if (meta_q > SEL_W'(N_SRC)) begin
         sync_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= sel_raw;
         sync_q <= sync_d;
      end
   end

   assign sel_s = sync_q;

endmodule

// File: rtl/sig_router.sv
// Routes speaker/LED/display data from one of N_SRC engines to the board,
// inserting a muted, blanked window and an optional timed banner on each switch.
module sig_router
   import sig_pkg::*;
#(
   parameter  int unsigned N_SRC      = 3,
   parameter  int unsigned LED_W      = 8,
   parameter  int unsigned DIGITS     = 8,
   parameter  int unsigned MUTE_CYC   = 16,
   parameter  int unsigned BANNER_CYC = 100_000_000,
   localparam int unsigned SEL_W      = $clog2(N_SRC + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [SEL_W-1:0]          sel,
   input  logic [N_SRC-1:0]          spk_in,
   input  logic [N_SRC*LED_W-1:0]    led_in,
   input  logic [N_SRC*DIGITS*4-1:0] dig_in,
   input  logic [N_SRC*DIGITS*4-1:0] banner_in,
   output logic                      speaker,
   output logic [LED_W-1:0]          led,
   output logic [DIGITS*4-1:0]       digits,
   output logic [SEL_W-1:0]          cur_src,
   output logic                      switching
);

   localparam int unsigned DIG_W   = DIGITS * 4;
   localparam int unsigned CNT_MAX = (MUTE_CYC > BANNER_CYC) ? MUTE_CYC : BANNER_CYC;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned SPK_IW  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
   localparam int unsigned LED_IW  = $clog2(N_SRC * LED_W);
   localparam int unsigned DIG_IW  = $clog2(N_SRC * DIG_W);

   typedef logic [DIG_W-1:0] dig_t;
   localparam dig_t IDLE_MSG  = dig_t'(idle_msg(DIGITS));
   localparam dig_t BLANK_MSG = {DIGITS{DIG_BLANK}};

   logic [SEL_W-1:0] sel_s;

   state_e           state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [SEL_W-1:0] cur_src_q,   cur_src_d;
   logic             speaker_q,   speaker_d;
   logic [LED_W-1:0] led_q,       led_d;
   dig_t             digits_q,    digits_d;
   logic             switching_q, switching_d;

   logic [SEL_W-1:0]  src_idx;
   logic [SPK_IW-1:0] spk_base;
   logic [LED_IW-1:0] led_base;
   logic [DIG_IW-1:0] dig_base;

   sel_sync #(
      .N_SRC (N_SRC),
      .SEL_W (SEL_W)
   ) u_sel_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .sel_raw (sel),
      .sel_s   (sel_s)
   );

   // Next state; any select change restarts the mute window with the new code
   always_comb begin
      state_d   = state_q;
      cur_src_d = cur_src_q;
      cnt_d     = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
      if (sel_s != cur_src_q) begin
         state_d   = ST_MUTE;
         cnt_d     = CNT_W'(MUTE_CYC - 1);
         cur_src_d = sel_s;
      end else begin
         unique case (state_q)
            ST_MUTE: begin
               if (cnt_q == '0) begin
                  if (cur_src_q == '0) begin
                     state_d = ST_IDLE;
                  end else if (BANNER_CYC == 0) begin
                     state_d = ST_LIVE;
                  end else begin
                     state_d = ST_BANNER;
                     cnt_d   = CNT_W'(BANNER_CYC - 1);
                  end
               end
            end
            ST_BANNER: begin
               if (cnt_q == '0) begin
                  state_d = ST_LIVE;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   // Slice offsets of the source that will be active after this edge
   always_comb begin
      src_idx  = (cur_src_d == '0) ? '0 : cur_src_d - SEL_W'(1);
      spk_base = SPK_IW'(src_idx);
      led_base = LED_IW'(32'(src_idx) * LED_W);
      dig_base = DIG_IW'(32'(src_idx) * DIG_W);
   end

   // Outputs follow the next state so they line up with state_q
   always_comb begin
      speaker_d   = 1'b0;
      led_d       = '0;
      digits_d    = IDLE_MSG;
      switching_d = 1'b0;
      unique case (state_d)
         ST_MUTE: begin
            digits_d    = BLANK_MSG;
            switching_d = 1'b1;
         end
         ST_BANNER: begin
            speaker_d = spk_in[spk_base];
            led_d     = led_in[led_base +: LED_W];
            digits_d  = banner_in[dig_base +: DIG_W];
         end
         ST_LIVE: begin
            speaker_d = spk_in[spk_base];
            led_d     = led_in[led_base +: LED_W];
            digits_d  = dig_in[dig_base +: DIG_W];
         end
         default: begin
            digits_d = IDLE_MSG;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cur_src_q   <= '0;
         speaker_q   <= 1'b0;
         led_q       <= '0;
         digits_q    <= IDLE_MSG;
         switching_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cur_src_q   <= cur_src_d;
         speaker_q   <= speaker_d;
         led_q       <= led_d;
         digits_q    <= digits_d;
         switching_q <= switching_d;
      end
   end

   assign speaker   = speaker_q;
   assign led       = led_q;
   assign digits    = digits_q;
   assign cur_src   = cur_src_q;
   assign switching = switching_q;

endmodule

// File: tb/tb_sig_router.sv
// Directed bench for sig_router: main instance with a banner, second instance
// (four sources, no banner) to reach out-of-range select codes.
module tb_sig_router;

   localparam logic [31:0] IDLE  = 32'h6E770DDD;
   localparam logic [31:0] BLANK = 32'hDDDDDDDD;

   logic clk;
   logic rst_n;

   // main instance: N_SRC=3
   logic [1:0]  sel;
   logic [2:0]  spk_in;
   logic [23:0] led_in;
   logic [95:0] dig_in;
   logic [95:0] banner_in;
   logic        speaker;
   logic [7:0]  led;
   logic [31:0] digits;
   logic [1:0]  cur_src;
   logic        switching;

   // second instance: N_SRC=4, BANNER_CYC=0
   logic [2:0]   b_sel;
   logic [3:0]   b_spk_in;
   logic [31:0]  b_led_in;
   logic [127:0] b_dig_in;
   logic [127:0] b_banner_in;
   logic         b_speaker;
   logic [7:0]   b_led;
   logic [31:0]  b_digits;
   logic [2:0]   b_cur_src;
   logic         b_switching;

   int n_checks = 0;
   int n_fail   = 0;

   sig_router #(
      .N_SRC(3), .LED_W(8), .DIGITS(8), .MUTE_CYC(4), .BANNER_CYC(8)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .sel(sel), .spk_in(spk_in), .led_in(led_in),
      .dig_in(dig_in), .banner_in(banner_in), .speaker(speaker), .led(led),
      .digits(digits), .cur_src(cur_src), .switching(switching)
   );

   sig_router #(
      .N_SRC(4), .LED_W(8), .DIGITS(8), .MUTE_CYC(4), .BANNER_CYC(0)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .sel(b_sel), .spk_in(b_spk_in), .led_in(b_led_in),
      .dig_in(b_dig_in), .banner_in(b_banner_in), .speaker(b_speaker), .led(b_led),
      .digits(b_digits), .cur_src(b_cur_src), .switching(b_switching)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n       = 1'b1;
      sel         = 2'd0;
      spk_in      = 3'b010;
      led_in      = {8'h3C, 8'hA5, 8'h11};
      dig_in      = {32'h33333333, 32'h22222222, 32'h11111111};
      banner_in   = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1};
      b_sel       = 3'd0;
      b_spk_in    = 4'b0001;
      b_led_in    = {8'h44, 8'h33, 8'h22, 8'h81};
      b_dig_in    = {32'h4444AAAA, 32'h3333AAAA, 32'h2222AAAA, 32'h1111AAAA};
      b_banner_in = {4{32'hBBBBBBBB}};

      // 1: reset and idle message
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_digits", 64'(digits), 64'(IDLE));
      check_eq("rst_led", 64'(led), 64'h0);
      check_eq("rst_switching", 64'(switching), 64'h0);
      step(2);
      rst_n = 1'b1;
      step(3);
      check_eq("idle_digits", 64'(digits), 64'(IDLE));
      check_eq("idle_cur_src", 64'(cur_src), 64'h0);
      step(20);
      check_eq("idle_hold_digits", 64'(digits), 64'(IDLE));
      check_eq("idle_hold_speaker", 64'(speaker), 64'h0);

      // 2: 0 -> 2, mute on cycles 3..6, banner 8 cycles, then live
      sel = 2'd2;
      step(2);
      check_eq("t2_pre_switching", 64'(switching), 64'h0);
      step(1);
      check_eq("t2_mute_switching", 64'(switching), 64'h1);
      check_eq("t2_mute_digits", 64'(digits), 64'(BLANK));
      check_eq("t2_mute_led", 64'(led), 64'h0);
      check_eq("t2_mute_speaker", 64'(speaker), 64'h0);
      check_eq("t2_cur_src", 64'(cur_src), 64'h2);
      step(3);
      check_eq("t2_mute_end_switching", 64'(switching), 64'h1);
      step(1);
      check_eq("t2_banner_switching", 64'(switching), 64'h0);
      check_eq("t2_banner_digits", 64'(digits), 64'hB2B2B2B2);
      check_eq("t2_banner_led", 64'(led), 64'hA5);
      check_eq("t2_banner_speaker", 64'(speaker), 64'h1);
      step(7);
      check_eq("t2_banner_last", 64'(digits), 64'hB2B2B2B2);
      step(1);
      check_eq("t2_live_digits", 64'(digits), 64'h22222222);
      check_eq("t2_live_led", 64'(led), 64'hA5);
      dig_in[63:32] = 32'h12345678;
      step(1);
      check_eq("t2_live_follow", 64'(digits), 64'h12345678);

      // 3: 1 -> 3 -> 2 inside mute; last code wins, src3 never shown
      sel = 2'd1;
      step(3);
      check_eq("t3_cur_src1", 64'(cur_src), 64'h1);
      sel = 2'd3;
      step(3);
      check_eq("t3_cur_src3", 64'(cur_src), 64'h3);
      check_eq("t3_led_blank3", 64'(led), 64'h0);
      sel = 2'd2;
      step(3);
      check_eq("t3_cur_src2", 64'(cur_src), 64'h2);
      check_eq("t3_switching", 64'(switching), 64'h1);
      step(3);
      check_eq("t3_still_mute", 64'(switching), 64'h1);
      check_eq("t3_mute_digits", 64'(digits), 64'(BLANK));
      step(1);
      check_eq("t3_banner_digits", 64'(digits), 64'hB2B2B2B2);
      check_eq("t3_banner_led", 64'(led), 64'hA5);

      // 5: src1 speaker toggling, switch 1 -> 2 keeps speaker low in mute
      sel = 2'd1;
      step(15);
      check_eq("t5_live_cur_src", 64'(cur_src), 64'h1);
      for (int i = 0; i < 4; i++) begin
         spk_in[0] = ~spk_in[0];
         step(1);
         check_eq("t5_live_speaker", 64'(speaker), 64'(spk_in[0]));
      end
      sel = 2'd2;
      for (int i = 1; i <= 7; i++) begin
         spk_in[0] = ~spk_in[0];
         step(1);
         if (i >= 3 && i <= 6) begin
            check_eq("t5_mute_speaker", 64'(speaker), 64'h0);
         end
      end
      check_eq("t5_banner_speaker", 64'(speaker), 64'h1);

      // 6: async reset between edges in the middle of the banner
      step(2);
      check_eq("t6_in_banner", 64'(digits), 64'hB2B2B2B2);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t6_rst_digits", 64'(digits), 64'(IDLE));
      check_eq("t6_rst_led", 64'(led), 64'h0);
      check_eq("t6_rst_speaker", 64'(speaker), 64'h0);
      check_eq("t6_rst_cur_src", 64'(cur_src), 64'h0);
      sel = 2'd0;
      step(2);
      rst_n = 1'b1;
      step(3);
      check_eq("t6_post_idle", 64'(digits), 64'(IDLE));

      // 4: out-of-range code on the four-source instance acts as idle
      b_sel = 3'd1;
      step(3);
      check_eq("t4_sel1_switching", 64'(b_switching), 64'h1);
      step(4);
      check_eq("t4_live_led", 64'(b_led), 64'h81);
      check_eq("t4_live_digits", 64'(b_digits), 64'h1111AAAA);
      check_eq("t4_live_speaker", 64'(b_speaker), 64'h1);
      b_sel = 3'd5;
      step(3);
      check_eq("t4_oor_cur_src", 64'(b_cur_src), 64'h0);
      check_eq("t4_oor_switching", 64'(b_switching), 64'h1);
      check_eq("t4_oor_led", 64'(b_led), 64'h0);
      step(3);
      check_eq("t4_oor_mute_end", 64'(b_digits), 64'(BLANK));
      step(1);
      check_eq("t4_idle_digits", 64'(b_digits), 64'(IDLE));
      check_eq("t4_idle_switching", 64'(b_switching), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
